// File: rtl/delay_timer_prog.sv
// delay_timer_prog: programmable trigger-to-timeout delay with prescaled ticks,
// one-shot/periodic modes, cancel, elapsed-tick readout and a saturating fire counter.
module delay_timer_prog #(
    parameter int BIT_SZ   = 14,
    parameter int PRESCALE = 50000,
    parameter int PS_SZ    = 16
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              trigger,
    input  logic              cancel,
    input  logic              mode,
    input  logic [BIT_SZ-1:0] N,
    output logic              time_out,
    output logic              busy,
    output logic [1:0]        state,
    output logic [BIT_SZ-1:0] N_out,
    output logic [7:0]        fire_cnt
);
    typedef enum logic [1:0] {IDLE = 2'b00, COUNTING = 2'b01, TIME_OUT = 2'b10, WAIT_LOW = 2'b11} state_t;
    localparam logic [PS_SZ-1:0] PS_MAX = PS_SZ'(PRESCALE - 1);
    state_t            r_state, w_next;
    logic [BIT_SZ-1:0] r_count, r_n_lat, r_n_out;
    logic [PS_SZ-1:0]  r_ps;
    logic [7:0]        r_fire;
    logic              r_mode_lat, r_trig_d;
    logic              w_start, w_tick, w_expire;
    assign w_start  = trigger & ~r_trig_d;
    assign w_tick   = r_ps == PS_MAX;
    // count==0 only happens for N=0, which expires on the first counting edge
    assign w_expire = (r_count == '0) || (w_tick && r_count == BIT_SZ'(1));
    assign time_out = r_state == TIME_OUT;
    assign busy     = (r_state == COUNTING) || (r_state == TIME_OUT);
    assign state    = r_state;
    assign N_out    = r_n_out;
    assign fire_cnt = r_fire;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_start ? COUNTING : IDLE;
            COUNTING: w_next = cancel ? WAIT_LOW : w_expire ? TIME_OUT : COUNTING;
            TIME_OUT: w_next = cancel ? WAIT_LOW : r_mode_lat ? COUNTING : trigger ? WAIT_LOW : IDLE;
            default:  w_next = trigger ? WAIT_LOW : IDLE;
        endcase
    end
    always_ff @(posedge sysclk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_count    <= '0;
            r_n_lat    <= '0;
            r_n_out    <= '0;
            r_ps       <= '0;
            r_fire     <= '0;
            r_mode_lat <= 1'b0;
            r_trig_d   <= 1'b1;
        end else begin
            r_trig_d <= trigger;
            case (r_state)
                IDLE: if (w_start) begin
                    r_n_lat    <= N;
                    r_mode_lat <= mode;
                    r_count    <= N;
                    r_ps       <= '0;
                    r_fire     <= '0;
                end
                COUNTING: if (cancel) r_n_out <= r_n_lat - r_count;
                else begin
                    r_ps <= w_tick ? '0 : r_ps + PS_SZ'(1);
                    if (w_tick && r_count != '0) r_count <= r_count - BIT_SZ'(1);
                    if (w_expire) begin
                        r_n_out <= r_n_lat;
                        if (r_fire != 8'hFF) r_fire <= r_fire + 8'd1;
                    end
                end
                TIME_OUT: if (cancel) r_n_out <= r_n_lat - r_count;
                else if (r_mode_lat) begin
                    r_count <= r_n_lat;
                    r_ps    <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_delay_timer_prog.sv
// tb_delay_timer_prog: directed checks of two timers (PRESCALE=1 and PRESCALE=4)
// sharing one stimulus; outputs sampled 1ns after each rising edge.
module tb_delay_timer_prog;
    logic        sysclk = 0, rst = 1, trigger = 1, cancel = 0, mode = 0;
    logic [13:0] N = 0;
    logic        to1, busy1, to4, busy4;
    logic [1:0]  st1, st4;
    logic [13:0] nout1, nout4;
    logic [7:0]  fc1, fc4;
    int          errors = 0, checks = 0;

    always #5 sysclk = ~sysclk;

    delay_timer_prog #(.BIT_SZ(14), .PRESCALE(1), .PS_SZ(16)) dut1 (
        .sysclk(sysclk), .rst(rst), .trigger(trigger), .cancel(cancel), .mode(mode), .N(N),
        .time_out(to1), .busy(busy1), .state(st1), .N_out(nout1), .fire_cnt(fc1));
    delay_timer_prog #(.BIT_SZ(14), .PRESCALE(4), .PS_SZ(16)) dut4 (
        .sysclk(sysclk), .rst(rst), .trigger(trigger), .cancel(cancel), .mode(mode), .N(N),
        .time_out(to4), .busy(busy4), .state(st4), .N_out(nout4), .fire_cnt(fc4));

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; trigger = 1;
        repeat (3) step();
        checks++; if (st1 !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", st1); end
        checks++; if (nout1 !== 14'd0) begin errors++; $display("FAIL reset_nout got=%0d exp=0", nout1); end
        checks++; if (fc1 !== 8'd0) begin errors++; $display("FAIL reset_fire got=%0d exp=0", fc1); end
        checks++; if ({to1, busy1} !== 2'b00) begin errors++; $display("FAIL reset_to_busy got=%b exp=00", {to1, busy1}); end
        checks++; if (st4 !== 2'b00) begin errors++; $display("FAIL reset_state4 got=%b exp=00", st4); end
        rst = 0;
        repeat (3) step();
        checks++; if (st1 !== 2'b00) begin errors++; $display("FAIL held_trig_no_start got=%b exp=00", st1); end
    endtask

    task automatic test_zero_n();
        trigger = 0; N = 0; mode = 0;
        step();
        trigger = 1;
        step();
        checks++; if (st1 !== 2'b01) begin errors++; $display("FAIL zero_start got=%b exp=01", st1); end
        step();
        checks++; if ({st1, to1} !== 3'b101) begin errors++; $display("FAIL zero_timeout got=%b exp=101", {st1, to1}); end
        checks++; if (to4 !== 1'b1) begin errors++; $display("FAIL zero_timeout4 got=%b exp=1", to4); end
        step();
        checks++; if ({st1, to1} !== 3'b110) begin errors++; $display("FAIL zero_waitlow got=%b exp=110", {st1, to1}); end
        trigger = 0;
        step();
        checks++; if (st1 !== 2'b00) begin errors++; $display("FAIL zero_idle got=%b exp=00", st1); end
    endtask

    task automatic test_oneshot();
        N = 5; mode = 0; trigger = 1;
        step();
        checks++; if ({st1, busy1} !== 3'b011) begin errors++; $display("FAIL os_start got=%b exp=011", {st1, busy1}); end
        for (int j = 1; j <= 4; j++) begin
            step();
            checks++; if ({st1, to1} !== 3'b010) begin errors++; $display("FAIL os_count%0d got=%b exp=010", j, {st1, to1}); end
        end
        step();
        checks++; if ({st1, to1} !== 3'b101) begin errors++; $display("FAIL os_expire got=%b exp=101", {st1, to1}); end
        checks++; if (nout1 !== 14'd5) begin errors++; $display("FAIL os_nout got=%0d exp=5", nout1); end
        checks++; if (fc1 !== 8'd1) begin errors++; $display("FAIL os_fire got=%0d exp=1", fc1); end
        step();
        checks++; if ({st1, to1, busy1} !== 4'b1100) begin errors++; $display("FAIL os_waitlow got=%b exp=1100", {st1, to1, busy1}); end
        trigger = 0;
        step();
        checks++; if (st1 !== 2'b00) begin errors++; $display("FAIL os_idle got=%b exp=00", st1); end
        repeat (25) step();
        checks++; if (st4 !== 2'b00) begin errors++; $display("FAIL os_idle4 got=%b exp=00", st4); end
    endtask

    task automatic test_prescale();
        N = 3; mode = 0; trigger = 1;
        step();
        checks++; if ({st4, busy4} !== 3'b011) begin errors++; $display("FAIL ps_start got=%b exp=011", {st4, busy4}); end
        for (int j = 1; j <= 11; j++) begin
            step();
            checks++; if ({busy4, to4} !== 2'b10) begin errors++; $display("FAIL ps_count%0d got=%b exp=10", j, {busy4, to4}); end
        end
        step();
        checks++; if ({busy4, to4} !== 2'b11) begin errors++; $display("FAIL ps_expire got=%b exp=11", {busy4, to4}); end
        checks++; if (nout4 !== 14'd3) begin errors++; $display("FAIL ps_nout got=%0d exp=3", nout4); end
        step();
        checks++; if ({st4, busy4} !== 3'b110) begin errors++; $display("FAIL ps_waitlow got=%b exp=110", {st4, busy4}); end
        trigger = 0;
        step();
        checks++; if ({st4, st1} !== 4'b0000) begin errors++; $display("FAIL ps_idle got=%b exp=0000", {st4, st1}); end
    endtask

    task automatic test_periodic();
        N = 4; mode = 1; trigger = 1;
        step();
        trigger = 0;
        for (int p = 1; p <= 3; p++) begin
            repeat (p == 1 ? 3 : 4) begin
                step();
                checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL per_gap%0d got=%b exp=0", p, to1); end
            end
            step();
            checks++; if (to1 !== 1'b1) begin errors++; $display("FAIL per_pulse%0d got=%b exp=1", p, to1); end
            checks++; if (fc1 !== 8'(p)) begin errors++; $display("FAIL per_fire%0d got=%0d exp=%0d", p, fc1, p); end
        end
        cancel = 1;
        step();
        cancel = 0;
        checks++; if ({st1, to1} !== 3'b110) begin errors++; $display("FAIL per_cancel got=%b exp=110", {st1, to1}); end
        checks++; if (fc1 !== 8'd3) begin errors++; $display("FAIL per_fire_hold got=%0d exp=3", fc1); end
        checks++; if (nout1 !== 14'd4) begin errors++; $display("FAIL per_nout got=%0d exp=4", nout1); end
        step();
        checks++; if ({st1, st4} !== 4'b0000) begin errors++; $display("FAIL per_idle got=%b exp=0000", {st1, st4}); end
    endtask

    task automatic test_cancel();
        N = 10; mode = 0; trigger = 1;
        step();
        repeat (6) begin
            step();
            checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL can_no_pulse got=%b exp=0", to1); end
        end
        cancel = 1;
        step();
        cancel = 0; trigger = 0;
        checks++; if ({st1, to1, busy1} !== 4'b1100) begin errors++; $display("FAIL can_state got=%b exp=1100", {st1, to1, busy1}); end
        checks++; if (nout1 !== 14'd6) begin errors++; $display("FAIL can_nout got=%0d exp=6", nout1); end
        step();
        checks++; if (st1 !== 2'b00) begin errors++; $display("FAIL can_idle got=%b exp=00", st1); end
        trigger = 1;
        step();
        repeat (9) step();
        cancel = 1;
        step();
        cancel = 0; trigger = 0;
        checks++; if ({st1, to1} !== 3'b110) begin errors++; $display("FAIL can_edge_state got=%b exp=110", {st1, to1}); end
        checks++; if (nout1 !== 14'd9) begin errors++; $display("FAIL can_edge_nout got=%0d exp=9", nout1); end
        checks++; if (fc1 !== 8'd0) begin errors++; $display("FAIL can_edge_fire got=%0d exp=0", fc1); end
        step();
        checks++; if ({st1, st4} !== 4'b0000) begin errors++; $display("FAIL can_edge_idle got=%b exp=0000", {st1, st4}); end
    endtask

    task automatic test_rst_mid();
        N = 2; mode = 1; trigger = 1;
        step();
        repeat (6) step();
        checks++; if (st1 !== 2'b01) begin errors++; $display("FAIL rm_counting got=%b exp=01", st1); end
        checks++; if (fc1 !== 8'd2) begin errors++; $display("FAIL rm_fire_pre got=%0d exp=2", fc1); end
        rst = 1;
        step();
        rst = 0; trigger = 0;
        checks++; if ({st1, to1, busy1} !== 4'b0000) begin errors++; $display("FAIL rm_state got=%b exp=0000", {st1, to1, busy1}); end
        checks++; if (nout1 !== 14'd0) begin errors++; $display("FAIL rm_nout got=%0d exp=0", nout1); end
        checks++; if (fc1 !== 8'd0) begin errors++; $display("FAIL rm_fire got=%0d exp=0", fc1); end
        checks++; if (st4 !== 2'b00) begin errors++; $display("FAIL rm_state4 got=%b exp=00", st4); end
    endtask

    initial begin
        test_reset();
        test_zero_n();
        test_oneshot();
        test_prescale();
        test_periodic();
        test_cancel();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
